mem_except_ctrl: RTL and testbench
==================================

Name: mem_except_ctrl

Overview:
- MEM-stage exception resolver placed directly upstream of the CP0 register file.
- Each cycle it merges the exception flags carried by the instruction in MEM with pending hardware/timer interrupts, and selects one exception code.
- It drives the CP0 exception inputs (excepttype, instruction address, delay-slot flag) through a registered interface.
- It issues the pipeline flush plus redirect PC (exception vector, or EPC for ERET) and forwards in-flight CP0 writes so decisions use up-to-date STATUS/CAUSE/EPC.

Parameters:
- EXC_VECTOR, 32'h00000020, redirect PC for every exception except ERET.
- FLUSH_CYCLES, 1, number of cycles flush_o is held high (1..7).

Ports:
- clk  input  1  clock, all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- inst_valid_i  input  1  MEM stage holds a real instruction (0 = bubble)
- excflags_i  input  32  raw flags: [8] syscall, [9] invalid inst, [10] trap, [11] overflow, [12] eret; other bits ignored
- inst_addr_i  input  32  PC of the MEM instruction
- in_delayslot_i  input  1  MEM instruction is in a branch delay slot
- cp0_status_i  input  32  CP0 STATUS read value
- cp0_cause_i  input  32  CP0 CAUSE read value
- cp0_epc_i  input  32  CP0 EPC read value
- wb_cp0_we_i  input  1  WB-stage CP0 write enable
- wb_cp0_addr_i  input  5  WB-stage CP0 write register number (12 STATUS, 13 CAUSE, 14 EPC)
- wb_cp0_data_i  input  32  WB-stage CP0 write data
- excepttype_o  output  32  registered code to CP0: 0x1 int, 0x8 syscall, 0xa inv, 0xd trap, 0xc ov, 0xe eret, 0 none
- cur_inst_addr_o  output  32  registered inst_addr_i for CP0
- is_in_delayslot_o  output  1  registered in_delayslot_i for CP0
- flush_o  output  1  flush all pipeline registers
- new_pc_o  output  32  redirect target, valid while flush_o=1
- busy_o  output  1  FSM not IDLE

Behaviour:
- Forwarding (combinational):
  - eff_status = wb_cp0_data_i if wb_cp0_we_i and addr==12, else cp0_status_i.
  - eff_epc: same rule with addr 14.
  - eff_cause[9:8] = wb data[9:8] when addr==13; all other eff_cause bits come from cp0_cause_i.
- Interrupt pending = |(eff_cause[15:8] & eff_status[15:8]) AND eff_status[0]==1 AND eff_status[1]==0.
- Exception selection, evaluated only when inst_valid_i=1 and state==IDLE. Fixed priority:
  - interrupt (0x1) > syscall (0x8) > invalid (0xa) > trap (0xd) > overflow (0xc) > eret (0xe).
  - A pending interrupt is taken even if flags are also set; exactly one code per cycle.
- FSM:
  - IDLE: on any selected code, register excepttype_o, cur_inst_addr_o and is_in_delayslot_o at the next edge (latency 1). In the same edge assert flush_o, latch new_pc_o, and move to FLUSH.
  - new_pc_o = eff_epc sampled at selection for 0xe, else EXC_VECTOR.
  - FLUSH: excepttype_o returns to 0 after exactly one cycle, so CP0 sees each exception once. flush_o is held for FLUSH_CYCLES cycles via a 3-bit down-counter, then the FSM enters IDLE with flush_o=0.
  - While in FLUSH, all inputs are ignored, including new interrupts; they stay pending in CP0 and are taken after return to IDLE.
- No exception: excepttype_o=0, flush_o=0, new_pc_o holds its last value.
- Bubble (inst_valid_i=0): no exception, even if an interrupt is pending. The interrupt waits for a valid instruction.
- Simultaneous WB write to STATUS clearing IE and a pending interrupt: the forwarded value wins, so no interrupt is taken.
- Reset (any time, including mid-FLUSH): state=IDLE, excepttype_o=0, cur_inst_addr_o=0, is_in_delayslot_o=0, flush_o=0, new_pc_o=0, busy_o=0, counter=0.

Optional Feature:
- Macro: MEM_EXCEPT_CTRL_STATS_EN.
- Defined: adds output exc_count_o [15:0], a saturating count of exceptions taken (incremented on each IDLE->FLUSH transition, held at 16'hFFFF). Reset value 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared define file holds:
  - exception codes (EXC_INT, EXC_SYSCALL, EXC_INV, EXC_TRAP, EXC_OV, EXC_ERET)
  - flag bit indices
  - CP0 register numbers
  - FSM state encodings (IDLE, FLUSH)
- One sub-module is natural: mem_except_prio, a purely combinational forward-and-priority encoder. The top keeps the FSM, counters and output registers.

Test Plan:
- excflags_i[8]=1, inst_addr_i=0x100, no delay slot -> next cycle excepttype_o=0x8, cur_inst_addr_o=0x100, flush_o=1, new_pc_o=0x20; excepttype_o=0 one cycle later; flush_o low after FLUSH_CYCLES.
- status=0x0000FF01, cause[10]=1, excflags_i[11]=1 -> excepttype_o=0x1 (interrupt beats overflow).
- excflags_i[12]=1, cp0_epc_i=0x200, WB writes EPC=0x300 same cycle -> new_pc_o=0x300, excepttype_o=0xe.
- Pending interrupt, status IE=1, WB writes STATUS=0x0000FF00 same cycle -> no flush, excepttype_o=0.
- Trap taken, then syscall presented during FLUSH -> ignored; syscall re-presented in IDLE -> taken with code 0x8.
- rst pulsed mid-FLUSH -> all outputs 0 immediately (asynchronous), busy_o=0; with STATS_EN, exc_count_o=0.

Source files
------------

// File: rtl/mem_except_ctrl_pkg.sv
// Shared definitions for the MEM-stage exception resolver.
// Holds the exception codes handed to CP0, the excflags bit positions,
// the CP0 register numbers used for write forwarding, and the FSM states.
package mem_except_ctrl_pkg;

  // Exception codes driven onto excepttype_o
  localparam logic [31:0] EXC_NONE    = 32'h0000_0000;
  localparam logic [31:0] EXC_INT     = 32'h0000_0001;
  localparam logic [31:0] EXC_SYSCALL = 32'h0000_0008;
  localparam logic [31:0] EXC_INV     = 32'h0000_000a;
  localparam logic [31:0] EXC_TRAP    = 32'h0000_000d;
  localparam logic [31:0] EXC_OV      = 32'h0000_000c;
  localparam logic [31:0] EXC_ERET    = 32'h0000_000e;

  // Bit positions inside excflags_i
  localparam int FLAG_SYSCALL = 8;
  localparam int FLAG_INV     = 9;
  localparam int FLAG_TRAP    = 10;
  localparam int FLAG_OV      = 11;
  localparam int FLAG_ERET    = 12;

  // CP0 register numbers
  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

endpackage

// File: rtl/mem_except_ctrl_prio.sv
// mem_except_prio: combinational CP0 write forwarding plus fixed-priority
// exception encoder.
// Ports:
//   i_inst_valid  MEM holds a real instruction
//   i_flags       raw exception flags from MEM
//   i_status/i_cause/i_epc  CP0 read values
//   i_wb_we/i_wb_addr/i_wb_data  WB-stage CP0 write, forwarded here
//   o_code        selected exception code (0 = none)
//   o_eff_epc     EPC after forwarding (ERET target)
module mem_except_prio
  import mem_except_ctrl_pkg::*;
(
  input  logic        i_inst_valid,
  input  logic [31:0] i_flags,
  input  logic [31:0] i_status,
  input  logic [31:0] i_cause,
  input  logic [31:0] i_epc,
  input  logic        i_wb_we,
  input  logic [4:0]  i_wb_addr,
  input  logic [31:0] i_wb_data,
  output logic [31:0] o_code,
  output logic [31:0] o_eff_epc
);

  logic [31:0] w_status;
  logic [31:0] w_cause;
  logic        w_int;
  logic        w_unused_bits;

  always_comb begin
    w_status  = (i_wb_we && i_wb_addr == CP0_STATUS) ? i_wb_data : i_status;
    o_eff_epc = (i_wb_we && i_wb_addr == CP0_EPC)    ? i_wb_data : i_epc;
    // Only the software interrupt bits of CAUSE are writable.
    w_cause   = i_cause;
    if (i_wb_we && i_wb_addr == CP0_CAUSE) w_cause[9:8] = i_wb_data[9:8];
  end

  // Pending = any unmasked IP bit, IE set, not in EXL.
  assign w_int = (|(w_cause[15:8] & w_status[15:8])) & w_status[0] & ~w_status[1];

  always_comb begin
    o_code = EXC_NONE;
    if (i_inst_valid) begin
      if      (w_int)                 o_code = EXC_INT;
      else if (i_flags[FLAG_SYSCALL]) o_code = EXC_SYSCALL;
      else if (i_flags[FLAG_INV])     o_code = EXC_INV;
      else if (i_flags[FLAG_TRAP])    o_code = EXC_TRAP;
      else if (i_flags[FLAG_OV])      o_code = EXC_OV;
      else if (i_flags[FLAG_ERET])    o_code = EXC_ERET;
    end
  end

  assign w_unused_bits = ^{w_status[31:16], w_status[7:2], w_cause[31:16],
                           w_cause[7:0], i_flags[31:13], i_flags[7:0]};

endmodule

// File: rtl/mem_except_ctrl.sv
// mem_except_ctrl: MEM-stage exception resolver feeding CP0.
// Selects one exception per valid instruction, registers the code, PC and
// delay-slot flag for CP0 (code pulses for one cycle), then flushes the
// pipeline for FLUSH_CYCLES cycles while redirecting to EXC_VECTOR or EPC.
// Ports: clk, rst (async, active high); MEM inputs inst_valid_i, excflags_i,
// inst_addr_i, in_delayslot_i; CP0 reads cp0_status_i/cause_i/epc_i; WB write
// wb_cp0_we_i/addr_i/data_i; outputs excepttype_o, cur_inst_addr_o,
// is_in_delayslot_o, flush_o, new_pc_o, busy_o.
// Optional: define MEM_EXCEPT_CTRL_STATS_EN to add exc_count_o, a saturating
// count of exceptions taken.
module mem_except_ctrl
  import mem_except_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
  parameter int          FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid_i,
  input  logic [31:0] excflags_i,
  input  logic [31:0] inst_addr_i,
  input  logic        in_delayslot_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_addr_i,
  input  logic [31:0] wb_cp0_data_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] cur_inst_addr_o,
  output logic        is_in_delayslot_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        busy_o
`ifdef MEM_EXCEPT_CTRL_STATS_EN
  ,
  output logic [15:0] exc_count_o
`endif
);

  localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES - 1);

  state_t      r_state;
  logic [2:0]  r_cnt;
  logic [31:0] w_code;
  logic [31:0] w_eff_epc;
  logic        w_take;

  mem_except_prio u_prio (
    .i_inst_valid (inst_valid_i),
    .i_flags      (excflags_i),
    .i_status     (cp0_status_i),
    .i_cause      (cp0_cause_i),
    .i_epc        (cp0_epc_i),
    .i_wb_we      (wb_cp0_we_i),
    .i_wb_addr    (wb_cp0_addr_i),
    .i_wb_data    (wb_cp0_data_i),
    .o_code       (w_code),
    .o_eff_epc    (w_eff_epc)
  );

  // Inputs only matter in IDLE; anything arriving in FLUSH stays pending
  // upstream and is picked up once we are back.
  assign w_take = (r_state == ST_IDLE) && (w_code != EXC_NONE);
  assign busy_o = (r_state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state           <= ST_IDLE;
      r_cnt             <= 3'd0;
      excepttype_o      <= 32'h0;
      cur_inst_addr_o   <= 32'h0;
      is_in_delayslot_o <= 1'b0;
      flush_o           <= 1'b0;
      new_pc_o          <= 32'h0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_take) begin
            // PC/delay-slot are captured only with an exception so CP0
            // always sees the context of the faulting instruction.
            excepttype_o      <= w_code;
            cur_inst_addr_o   <= inst_addr_i;
            is_in_delayslot_o <= in_delayslot_i;
            flush_o           <= 1'b1;
            new_pc_o          <= (w_code == EXC_ERET) ? w_eff_epc : EXC_VECTOR;
            r_cnt             <= FLUSH_LAST;
            r_state           <= ST_FLUSH;
          end else begin
            excepttype_o <= EXC_NONE;
            flush_o      <= 1'b0;
          end
        end
        ST_FLUSH: begin
          excepttype_o <= EXC_NONE;
          if (r_cnt == 3'd0) begin
            flush_o <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef MEM_EXCEPT_CTRL_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  exc_count_o <= 16'h0;
    else if (w_take && exc_count_o != 16'hFFFF) exc_count_o <= exc_count_o + 16'd1;
  end
`endif

endmodule

// File: tb/tb_mem_except_ctrl.sv
module tb_mem_except_ctrl;

  localparam logic [31:0] VEC = 32'h0000_0080;
  localparam int          FC  = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_valid;
  logic [31:0] excflags;
  logic [31:0] inst_addr;
  logic        in_ds;
  logic [31:0] status, cause, epc;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] excepttype, cur_addr, new_pc;
  logic        is_ds, flush, busy;
`ifdef MEM_EXCEPT_CTRL_STATS_EN
  logic [15:0] exc_count;
`endif

  mem_except_ctrl #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(FC)) dut (
    .clk               (clk),
    .rst               (rst),
    .inst_valid_i      (inst_valid),
    .excflags_i        (excflags),
    .inst_addr_i       (inst_addr),
    .in_delayslot_i    (in_ds),
    .cp0_status_i      (status),
    .cp0_cause_i       (cause),
    .cp0_epc_i         (epc),
    .wb_cp0_we_i       (wb_we),
    .wb_cp0_addr_i     (wb_addr),
    .wb_cp0_data_i     (wb_data),
    .excepttype_o      (excepttype),
    .cur_inst_addr_o   (cur_addr),
    .is_in_delayslot_o (is_ds),
    .flush_o           (flush),
    .new_pc_o          (new_pc),
    .busy_o            (busy)
`ifdef MEM_EXCEPT_CTRL_STATS_EN
    ,
    .exc_count_o       (exc_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] exc, addr, pc;
    logic        ds, flush, busy;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Reference model state: cycles of flush remaining plus last captured values
  int          m_left = 0;
  logic [31:0] m_exc = 0, m_addr = 0, m_pc = 0;
  logic        m_ds = 0;
  int          m_cnt = 0;
  logic [31:0] codes [5] = '{32'h8, 32'ha, 32'hd, 32'hc, 32'he};

  // One clock of the reference: what the outputs should be after the next edge.
  task automatic model_eval();
    logic [31:0] st, ca, ep, code;
    st = (wb_we && wb_addr == 5'd12) ? wb_data : status;
    ep = (wb_we && wb_addr == 5'd14) ? wb_data : epc;
    ca = cause;
    if (wb_we && wb_addr == 5'd13) ca[9:8] = wb_data[9:8];
    code = 0;
    if (m_left > 0) begin
      m_left = m_left - 1;
      m_exc  = 0;
    end else begin
      if (inst_valid) begin
        if ((((ca >> 8) & (st >> 8) & 32'hff) != 0) && st[0] && !st[1]) code = 1;
        else
          for (int k = 0; k < 5; k++)
            if (excflags[8+k]) begin code = codes[k]; break; end
      end
      m_exc = code;
      if (code != 0) begin
        m_addr = inst_addr;
        m_ds   = in_ds;
        m_pc   = (code == 32'he) ? ep : VEC;
        m_left = FC;
        if (m_cnt < 65535) m_cnt = m_cnt + 1;
      end
    end
  endtask

  task automatic step();
    exp_t e;
    model_eval();
    @(posedge clk);
    #1;
    e.exc = m_exc; e.addr = m_addr; e.pc = m_pc; e.ds = m_ds;
    e.flush = (m_left > 0); e.busy = (m_left > 0); e.cnt = 16'(m_cnt);
    q.push_back(e);
  endtask

  task automatic clr();
    inst_valid = 0; excflags = 0; inst_addr = 0; in_ds = 0;
    status = 0; cause = 0; epc = 0; wb_we = 0; wb_addr = 0; wb_data = 0;
  endtask

  task automatic idle(input int n);
    clr();
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " excepttype"}, excepttype, 0);
    chk({tag, " cur_addr"}, cur_addr, 0);
    chk({tag, " is_ds"}, {31'b0, is_ds}, 0);
    chk({tag, " flush"}, {31'b0, flush}, 0);
    chk({tag, " new_pc"}, new_pc, 0);
    chk({tag, " busy"}, {31'b0, busy}, 0);
`ifdef MEM_EXCEPT_CTRL_STATS_EN
    chk({tag, " exc_count"}, {16'b0, exc_count}, 0);
`endif
  endtask

  // Monitor: compares every queued expectation away from the active edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic bad;
      e = q.pop_front();
      n_chk++;
      bad = (excepttype !== e.exc) || (cur_addr !== e.addr) || (is_ds !== e.ds) ||
            (flush !== e.flush) || (new_pc !== e.pc) || (busy !== e.busy);
`ifdef MEM_EXCEPT_CTRL_STATS_EN
      if (exc_count !== e.cnt) bad = 1'b1;
`endif
      if (bad) begin
        n_fail++;
        $display("FAIL scoreboard t=%0t exc=%h/%h addr=%h/%h ds=%b/%b flush=%b/%b pc=%h/%h busy=%b/%b (got/expected)",
                 $time, excepttype, e.exc, cur_addr, e.addr, is_ds, e.ds,
                 flush, e.flush, new_pc, e.pc, busy, e.busy);
      end
    end
  end

  initial begin
    rst = 1'b1;
    clr();
    #2;
    chk_reset("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    // Syscall, outside a delay slot
    clr(); inst_valid = 1; excflags = 32'h100; inst_addr = 32'h100; step();
    idle(FC + 1);

    // Interrupt beats overflow, delay-slot capture
    clr(); inst_valid = 1; status = 32'h0000FF01; cause = 32'h400;
    excflags = 32'h800; inst_addr = 32'h1234; in_ds = 1; step();
    idle(FC + 1);

    // ERET with EPC forwarded from WB
    clr(); inst_valid = 1; excflags = 32'h1000; epc = 32'h200;
    wb_we = 1; wb_addr = 5'd14; wb_data = 32'h300; step();
    idle(FC + 1);

    // WB clears IE the same cycle: no interrupt; next cycle it is taken
    clr(); inst_valid = 1; status = 32'h0000FF01; cause = 32'h400;
    wb_we = 1; wb_addr = 5'd12; wb_data = 32'h0000FF00; step();
    wb_we = 0; step();
    idle(FC + 1);

    // Bubble with a pending interrupt: nothing happens
    clr(); status = 32'h0000FF01; cause = 32'h400; step(); step();

    // Software interrupt raised purely by a forwarded CAUSE write
    clr(); inst_valid = 1; status = 32'h0000FF01;
    wb_we = 1; wb_addr = 5'd13; wb_data = 32'h200; step();
    idle(FC + 1);

    // Trap, then syscall during FLUSH is ignored, retaken in IDLE
    clr(); inst_valid = 1; excflags = 32'h400; inst_addr = 32'h40; step();
    excflags = 32'h100; inst_addr = 32'h44;
    for (int i = 0; i < FC; i++) step();
    step();
    idle(FC + 1);

    // Reset mid-FLUSH
    clr(); inst_valid = 1; excflags = 32'h800; inst_addr = 32'h88; step();
    @(negedge clk);
    #1 rst = 1'b1;
    #1 chk_reset("mid-flush reset");
    #1 rst = 1'b0;
    m_left = 0; m_exc = 0; m_addr = 0; m_pc = 0; m_ds = 0; m_cnt = 0;
    idle(2);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      inst_valid = ($urandom_range(0, 3) != 0);
      excflags   = $urandom & ~32'h1F00;
      for (int k = 0; k < 5; k++)
        if ($urandom_range(0, 5) == 0) excflags[8+k] = 1'b1;
      inst_addr  = $urandom;
      in_ds      = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 3))
        0: status = 32'h0000FF01;
        1: status = 32'h0000FF03;
        2: status = 32'h0000FF00;
        default: status = $urandom;
      endcase
      cause   = ($urandom_range(0, 3) == 0) ? (32'h1 << $urandom_range(8, 15)) : ($urandom & 32'hFFFF00FF);
      epc     = $urandom;
      wb_we   = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0: wb_addr = 5'd12;
        1: wb_addr = 5'd13;
        2: wb_addr = 5'd14;
        default: wb_addr = 5'($urandom);
      endcase
      wb_data = $urandom;
      step();
    end
    idle(FC + 2);

    @(negedge clk);
    #1;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
